rate_unloader: RTL and testbench

Parallel-in/serial-out reader for the sponge datapath. Accepts one full rate block from the Keccak state register in a single load handshake, then streams it out one word per ready/valid beat, least-significant word first. Sits between the permutation core's state register and the SHAKE output port. Supplies the squeeze-side counterpart to the register/absorb path.

---
 rtl/shake_pkg.sv | 23 ++
 rtl/regn.sv | 32 +++
 rtl/rate_unloader.sv | 114 +++++++++++
 tb/tb_rate_unloader.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shake_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shake_pkg
//  Description : Shared constants and types for the SHAKE sponge datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package shake_pkg;

   // Width of one Keccak lane / output word
   localparam int WORD_W = 64;

   // Rate sizes in words for the two SHAKE variants
   localparam int SHAKE128_RATE_WORDS = 21;
   localparam int SHAKE256_RATE_WORDS = 17;

   // Rate unloader control states
   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } unl_state_e;

endpackage
`default_nettype wire

// File: rtl/regn.sv
`default_nettype none
// ============================================================================
//  Module      : regn
//  Description : Generic enabled register with synchronous reset to INIT.
//  Revision    : 1.0 - initial release
// ============================================================================
module regn #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] data_q;

   // Hold value unless enabled; reset returns to INIT
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= INIT;
      end else if (en_i) begin
         data_q <= data_i;
      end
   end

   assign q_o = data_q;

endmodule
`default_nettype wire

// File: rtl/rate_unloader.sv
`default_nettype none
// ============================================================================
//  Module      : rate_unloader
//  Description : Parallel-in / serial-out squeeze reader. Captures one rate
//                block in a single load handshake and streams it out one word
//                per ready/valid beat, least-significant word first.
//  Revision    : 1.0 - initial release
// ============================================================================
module rate_unloader
   import shake_pkg::*;
#(
   parameter int WORD_W    = shake_pkg::WORD_W,
   parameter int MAX_WORDS = shake_pkg::SHAKE128_RATE_WORDS
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             load_valid,
   output logic                             load_ready,
   input  logic [MAX_WORDS*WORD_W-1:0]      load_data,
   input  logic [$clog2(MAX_WORDS+1)-1:0]   load_words,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [WORD_W-1:0]                out_data,
   output logic                             out_last,
   output logic                             busy
);

   localparam int                 c_CNT_W   = $clog2(MAX_WORDS + 1);
   localparam int                 c_BUF_W   = MAX_WORDS * WORD_W;
   localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_WORDS);
   localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);
   localparam logic [c_CNT_W-1:0] c_TWO     = c_CNT_W'(2);

   unl_state_e         state_q;
   logic [c_CNT_W-1:0] remaining_q;
   logic               out_valid_q;
   logic               out_last_q;

   logic [c_BUF_W-1:0] buf_q;
   logic [c_BUF_W-1:0] buf_d;

   logic               w_load_hs;
   logic               w_beat;
   logic [c_CNT_W-1:0] w_sat_cnt;

   // Load side is only open in IDLE and is held shut while reset is asserted
   assign load_ready = (state_q == IDLE) && !rst;
   assign w_load_hs  = load_valid && load_ready;
   assign w_beat     = out_valid_q && out_ready;

   // Requests larger than the buffer are clipped to the buffer size
   assign w_sat_cnt  = (load_words > c_MAX_CNT) ? c_MAX_CNT : load_words;

   // A load overwrites the buffer; a beat drops the word just consumed
   assign buf_d      = w_load_hs ? load_data : (buf_q >> WORD_W);

   regn #(
      .WIDTH (c_BUF_W),
      .INIT  ({c_BUF_W{1'b0}})
   ) u_buf (
      .clk    (clk),
      .rst    (rst),
      .en_i   (w_load_hs || w_beat),
      .data_i (buf_d),
      .q_o    (buf_q)
   );

   // Control FSM: state, word counter and registered valid/last flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (load_valid) begin
                  remaining_q <= w_sat_cnt;
                  // An empty block is consumed without producing any output
                  if (w_sat_cnt != '0) begin
                     state_q     <= STREAM;
                     out_valid_q <= 1'b1;
                     out_last_q  <= (w_sat_cnt == c_ONE);
                  end
               end
            end
            STREAM: begin
               if (out_ready) begin
                  remaining_q <= remaining_q - c_ONE;
                  // Next word is the final one when two were outstanding
                  out_last_q  <= (remaining_q == c_TWO);
                  if (remaining_q == c_ONE) begin
                     state_q     <= IDLE;
                     out_valid_q <= 1'b0;
                  end
               end
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
               out_last_q  <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_data  = buf_q[WORD_W-1:0];
   assign busy      = (state_q == STREAM);

endmodule
`default_nettype wire

// File: tb/tb_rate_unloader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rate_unloader
//  Description : Self-checking bench for rate_unloader with a word scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rate_unloader;

   localparam int W  = 64;
   localparam int MW = 21;
   localparam int CW = $clog2(MW + 1);

   typedef logic [MW*W-1:0] blk_t;
   typedef struct {
      logic [W-1:0] d;
      logic         last;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          load_valid = 1'b0;
   logic          load_ready;
   blk_t          load_data = '0;
   logic [CW-1:0] load_words = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  out_data;
   logic          out_last;
   logic          busy;

   int   checks = 0;
   int   errors = 0;
   int   beats  = 0;
   int   cyc    = 0;
   exp_t sb[$];
   exp_t mon_e;

   rate_unloader #(.WORD_W(W), .MAX_WORDS(MW)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .load_words (load_words),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: every accepted word is compared to the next expected one
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         beats++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL beat_extra: got data=%h last=%b, required no beat", out_data, out_last);
         end else begin
            mon_e = sb.pop_front();
            if (out_data !== mon_e.d || out_last !== mon_e.last) begin
               errors++;
               $display("FAIL beat: got data=%h last=%b, required data=%h last=%b",
                        out_data, out_last, mon_e.d, mon_e.last);
            end
         end
      end
   end

   function automatic blk_t make_blk(input logic [W-1:0] base);
      blk_t b;
      for (int i = 0; i < MW; i++) b[i*W +: W] = base + W'(i);
      return b;
   endfunction

   // Reference model of what a load should produce on the output
   function automatic void push_block(input blk_t b, input int n);
      int   sat;
      exp_t e;
      sat = (n > MW) ? MW : n;
      for (int i = 0; i < sat; i++) begin
         e.d    = b[i*W +: W];
         e.last = (i == sat - 1);
         sb.push_back(e);
      end
   endfunction

   // Offer a block and wait for the handshake; returns at the handshake negedge
   task automatic do_load(input blk_t b, input int n, output int hs_cyc);
      bit done;
      done = 0;
      hs_cyc = 0;
      @(posedge clk); #1;
      load_valid = 1'b1;
      load_data  = b;
      load_words = CW'(n);
      for (int t = 0; t < 100 && !done; t++) begin
         @(negedge clk);
         if (load_ready) begin
            done   = 1;
            hs_cyc = cyc;
            push_block(b, n);
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL load_timeout: got load_ready=%b, required 1 within 100 cycles", load_ready);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: got valid=%b last=%b busy=%b, required 0 0 0", out_valid, out_last, busy);
      end
      checks++;
      if (out_data !== '0) begin
         errors++;
         $display("FAIL reset_data: got %h, required 0", out_data);
      end
      checks++;
      if (load_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_load_ready: got %b, required 0", load_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (load_ready !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_load_ready: got %b, required 1", load_ready);
      end
   endtask

   task automatic test_full_block;
      int hs;
      out_ready = 1'b1;
      do_load(make_blk(64'h1000), 21, hs);
      @(posedge clk); #1;
      load_valid = 1'b0;
      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_valid[%0d]: got %b, required 1", i, out_valid);
         end
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || load_ready !== 1'b1) begin
         errors++;
         $display("FAIL full_return_idle: got valid=%b load_ready=%b, required 0 1", out_valid, load_ready);
      end
   endtask

   task automatic test_backpressure;
      logic         pat [6];
      logic [W-1:0] held;
      bit           stalled;
      int           hs;
      int           b0;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      stalled = 0;
      held = '0;
      b0 = beats;
      do_load(make_blk(64'hB000), 3, hs);
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         out_ready = pat[k];
         if (k == 0) load_valid = 1'b0;
         @(negedge clk);
         if (stalled) begin
            checks++;
            if (out_data !== held || out_valid !== 1'b1) begin
               errors++;
               $display("FAIL stall_stable[%0d]: got valid=%b data=%h, required 1 %h", k, out_valid, out_data, held);
            end
         end
         stalled = out_valid && !out_ready;
         held    = out_data;
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || beats - b0 !== 3) begin
         errors++;
         $display("FAIL bp_beats: got valid=%b beats=%0d, required 0 3", out_valid, beats - b0);
      end
   endtask

   task automatic test_boundary_counts;
      int hs;
      int b0;
      out_ready = 1'b1;
      // zero words: accepted, nothing emitted
      do_load(make_blk(64'h5000), 0, hs);
      @(posedge clk); #1;
      load_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || load_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_words: got valid=%b load_ready=%b busy=%b, required 0 1 0", out_valid, load_ready, busy);
      end
      // oversize count saturates to the buffer size
      b0 = beats;
      do_load(make_blk(64'h6000), 31, hs);
      @(posedge clk); #1;
      load_valid = 1'b0;
      repeat (26) @(negedge clk);
      checks++;
      if (beats - b0 !== 21 || sb.size() !== 0) begin
         errors++;
         $display("FAIL saturate: got beats=%0d pending=%0d, required 21 0", beats - b0, sb.size());
      end
      // single word block
      do_load(make_blk(64'h7000), 1, hs);
      @(posedge clk); #1;
      load_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_last !== 1'b1) begin
         errors++;
         $display("FAIL one_word: got valid=%b last=%b, required 1 1", out_valid, out_last);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL one_word_end: got valid=%b, required 0", out_valid);
      end
   endtask

   task automatic test_hold_valid;
      int   hs_a;
      int   hs_b;
      blk_t junk;
      out_ready = 1'b1;
      do_load(make_blk(64'h3000), 21, hs_a);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         for (int j = 0; j < MW*W/32; j++) junk[j*32 +: 32] = $urandom;
         load_data  = junk;
         load_words = CW'($urandom_range(0, 31));
         @(negedge clk);
         checks++;
         if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_load_ready[%0d]: got %b, required 0", k, load_ready);
         end
      end
      do_load(make_blk(64'h4000), 5, hs_b);
      checks++;
      if (hs_b - hs_a !== 22) begin
         errors++;
         $display("FAIL hold_reload_gap: got %0d cycles, required 22", hs_b - hs_a);
      end
      @(posedge clk); #1;
      load_valid = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int  hs;
      int  b0;
      bit  hit;
      out_ready = 1'b1;
      b0  = beats;
      hit = 0;
      do_load(make_blk(64'hC000), 17, hs);
      @(posedge clk); #1;
      load_valid = 1'b0;
      for (int t = 0; t < 40 && !hit; t++) begin
         if (beats - b0 >= 5) hit = 1;
         else @(posedge clk);
      end
      #1;
      rst = 1'b1;
      sb.delete();
      checks++;
      if (!hit || beats - b0 !== 5) begin
         errors++;
         $display("FAIL mid_beats: got %0d beats before reset, required 5", beats - b0);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got valid=%b busy=%b load_ready=%b, required 0 0 0", out_valid, busy, load_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      b0 = beats;
      do_load(make_blk(64'hD000), 4, hs);
      @(posedge clk); #1;
      load_valid = 1'b0;
      repeat (8) @(negedge clk);
      checks++;
      if (beats - b0 !== 4 || sb.size() !== 0) begin
         errors++;
         $display("FAIL post_mid_block: got beats=%0d pending=%0d, required 4 0", beats - b0, sb.size());
      end
   endtask

   task automatic test_back_to_back;
      int hs;
      int prev;
      int b0;
      out_ready = 1'b1;
      b0   = beats;
      prev = 0;
      for (int b = 0; b < 4; b++) begin
         do_load(make_blk(64'h20000 + W'(b) * 64'h100), 17, hs);
         if (b > 0) begin
            checks++;
            if (hs - prev !== 18) begin
               errors++;
               $display("FAIL b2b_gap[%0d]: got %0d cycles, required 18", b, hs - prev);
            end
         end
         prev = hs;
      end
      @(posedge clk); #1;
      load_valid = 1'b0;
      repeat (20) @(negedge clk);
      checks++;
      if (beats - b0 !== 68 || sb.size() !== 0) begin
         errors++;
         $display("FAIL b2b_total: got beats=%0d pending=%0d, required 68 0", beats - b0, sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_full_block();
      test_backpressure();
      test_boundary_counts();
      test_hold_valid();
      test_reset_mid();
      test_back_to_back();
      checks++;
      if (sb.size() !== 0) begin
         errors++;
         $display("FAIL final_pending: got %0d words outstanding, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
